mem_access_arbiter: RTL and testbench

//  Shares the single 128-byte, 64-bit byte-addressed data memory between the instruction-fetch

---
 rtl/arm_mem_pkg.sv | 40 ++++
 rtl/mem_access_arbiter_if.sv | 39 +++
 rtl/mem_rr_arbiter.sv | 26 ++
 rtl/mem_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
//   state_e   : arbiter FSM states
//   grant_e   : which requester owns the memory
//   mem_txn_t : latched transaction payload (we/addr/wdata)
//   addr_in_range : true when all 8 bytes of a word access fit in memory
package arm_mem_pkg;

  localparam int unsigned ADDR_W             = 64;
  localparam int unsigned DATA_W             = 64;
  localparam int unsigned WORD_BYTES         = 8;
  localparam int unsigned DEF_MEM_BYTES      = 128;
  localparam int unsigned DEF_READ_CYCLES    = 2;
  localparam int unsigned DEF_WRITE_CYCLES   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_txn_t;

  // Sum is one bit wider than the address so a near-max address cannot wrap into range.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       mem_bytes);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, addr} + (ADDR_W+1)'(WORD_BYTES - 1);
    return last_byte <= (ADDR_W+1)'(mem_bytes - 1);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
//   slave  : seen by the arbiter (requests and mem_data_out in, responses and memory controls out)
//   master : seen by the environment (core ports and memory model)
interface mem_access_arbiter_if;
  import arm_mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_address, mem_data_in, mem_read, mem_write
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_address, mem_data_in, mem_read, mem_write
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin pick between fetch and data requests.
//   req_instr, req_data : pending requests
//   last_grant          : requester served most recently
//   grant_c, valid_c    : combinational winner and "someone is requesting"
module mem_rr_arbiter
  import arm_mem_pkg::*;
(
  input  logic   req_instr,
  input  logic   req_data,
  input  grant_e last_grant,
  output grant_e grant_c,
  output logic   valid_c
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_c = GRANT_INSTR;
    valid_c = req_instr | req_data;
    if (req_instr && req_data) begin
      grant_c = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (req_data) begin
      grant_c = GRANT_DATA;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one data memory between the instruction-fetch and load/store ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch port (i_*), data port (d_*) and memory controls (mem_*)
// One transaction at a time: IDLE picks a requester and latches it, ACCESS holds the
// memory controls for the fixed access time, RESP pulses the winner's ack.
module mem_access_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = DEF_MEM_BYTES,
  parameter int unsigned READ_CYCLES  = DEF_READ_CYCLES,
  parameter int unsigned WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_arbiter_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  mem_txn_t           txn_q, txn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  grant_e             grant_c;
  logic               valid_c;

  logic               ack_c, err_c;
  logic [DATA_W-1:0]  rdata_c;

  logic               mem_read_d, mem_write_d;
  logic               i_ack_d, i_err_d, d_ack_d, d_err_d;
  logic [DATA_W-1:0]  i_rdata_d, d_rdata_d;

  mem_rr_arbiter u_rr (
    .req_instr  (bus.i_req),
    .req_data   (bus.d_req),
    .last_grant (last_grant_q),
    .grant_c    (grant_c),
    .valid_c    (valid_c)
  );

  // Memory address/data come straight from the latched transaction, so they are stable
  // for the whole access window.
  assign bus.mem_address = txn_q.addr;
  assign bus.mem_data_in = txn_q.wdata;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    txn_d        = txn_q;
    cnt_d        = cnt_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ack_c        = 1'b0;
    err_c        = 1'b0;
    rdata_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (valid_c) begin
          last_grant_d = grant_c;
          if (grant_c == GRANT_DATA) begin
            txn_d.we    = bus.d_we;
            txn_d.addr  = bus.d_addr;
            txn_d.wdata = bus.d_wdata;
          end else begin
            txn_d.we    = 1'b0;
            txn_d.addr  = bus.i_addr;
            txn_d.wdata = '0;
          end
          cnt_d = txn_d.we ? CNT_W'(WRITE_CYCLES - 1) : CNT_W'(READ_CYCLES - 1);
          if (!addr_in_range(txn_d.addr, MEM_BYTES)) begin
            // Out-of-range: answer immediately, memory is never touched.
            state_d = ST_RESP;
            ack_c   = 1'b1;
            err_c   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_read_d  = ~txn_d.we;
            mem_write_d = txn_d.we;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          ack_c   = 1'b1;
          rdata_c = txn_q.we ? '0 : bus.mem_data_out;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          mem_read_d = ~txn_q.we;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Route the response to the granted port only; the other port sees zeros.
    i_ack_d   = ack_c && (last_grant_d == GRANT_INSTR);
    i_err_d   = err_c && (last_grant_d == GRANT_INSTR);
    i_rdata_d = (last_grant_d == GRANT_INSTR) ? rdata_c : '0;
    d_ack_d   = ack_c && (last_grant_d == GRANT_DATA);
    d_err_d   = err_c && (last_grant_d == GRANT_DATA);
    d_rdata_d = (last_grant_d == GRANT_DATA) ? rdata_c : '0;
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_INSTR;
      txn_q         <= '0;
      cnt_q         <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.i_ack     <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      txn_q         <= txn_d;
      cnt_q         <= cnt_d;
      bus.mem_read  <= mem_read_d;
      bus.mem_write <= mem_write_d;
      bus.i_ack     <= i_ack_d;
      bus.i_err     <= i_err_d;
      bus.i_rdata   <= i_rdata_d;
      bus.d_ack     <= d_ack_d;
      bus.d_err     <= d_err_d;
      bus.d_rdata   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: byte-array memory model on the memory side,
// reference memory + service-order model predicting ack timing, data and errors.
module tb_mem_access_arbiter;
  import arm_mem_pkg::*;

  localparam int unsigned MEMB = 128;
  localparam int unsigned RC   = 2;
  localparam int unsigned WC   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_access_arbiter_if bus();

  mem_access_arbiter #(.MEM_BYTES(MEMB), .READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int spurious = 0;

  // Physical memory attached to the DUT.
  logic [7:0]  phys_mem [MEMB];
  logic [7:0]  ref_mem  [MEMB];
  bit          preset_req = 1'b0;
  int          wr_base;
  logic [63:0] rd_word;

  always @(posedge clk) begin
    if (preset_req) begin
      for (int k = 0; k < int'(MEMB); k++) phys_mem[k] <= 8'(k);
    end else if (bus.mem_write && bus.mem_address <= 64'(MEMB - 8)) begin
      wr_base = int'(bus.mem_address[6:0]);
      for (int k = 0; k < 8; k++) phys_mem[wr_base + k] <= bus.mem_data_in[8*k +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (bus.mem_address <= 64'(MEMB - 8))
      for (int k = 0; k < 8; k++) rd_word[8*k +: 8] = phys_mem[int'(bus.mem_address[6:0]) + k];
  end

  // Garbage when not reading, so a capture at the wrong time shows up.
  assign bus.mem_data_out = bus.mem_read ? rd_word : 64'hBAD0_BAD0_BAD0_BAD0;

  // Memory-side protocol monitor.
  int          rd_cycles = 0, wr_pulses = 0, viol = 0, hold_cnt = 0;
  logic        prev_read = 1'b0, prev_write = 1'b0;
  logic [63:0] prev_addr = '0, held_addr = '0, held_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_cnt = 0; prev_read = 1'b0; prev_write = 1'b0;
    end else begin
      if (bus.mem_read)  rd_cycles++;
      if (bus.mem_write) wr_pulses++;
      if (bus.mem_write && prev_write) viol++;
      if (bus.mem_write && bus.mem_read) viol++;
      if (bus.mem_read && prev_read && bus.mem_address !== prev_addr) viol++;
      if (hold_cnt > 0) begin
        if (bus.mem_address !== held_addr || bus.mem_data_in !== held_data || bus.mem_read) viol++;
        hold_cnt--;
      end
      if (bus.mem_write) begin
        held_addr = bus.mem_address; held_data = bus.mem_data_in; hold_cnt = int'(WC) - 1;
      end
      prev_read = bus.mem_read; prev_write = bus.mem_write; prev_addr = bus.mem_address;
    end
  end

  // ---------------- reference model ----------------
  bit tie_to_data;

  function automatic bit legal(input logic [63:0] a);
    return a <= 64'(MEMB - 8);
  endfunction

  function automatic int exp_lat(input bit we, input bit ok);
    if (!ok) return 1;
    return we ? int'(WC) + 1 : int'(RC) + 1;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[int'(a[6:0]) + k];
    return r;
  endfunction

  task automatic model_apply(input bit we, input logic [63:0] a, input logic [63:0] wd,
                             output logic [63:0] xdata, output bit xerr);
    xerr  = !legal(a);
    xdata = '0;
    if (!xerr) begin
      if (we) for (int k = 0; k < 8; k++) ref_mem[int'(a[6:0]) + k] = wd[8*k +: 8];
      else    xdata = ref_read(a);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return {32'($urandom), 32'($urandom)};
    return 64'($urandom_range(0, 127));
  endfunction

  function automatic logic outs_nonzero();
    return |{bus.i_ack, bus.i_err, bus.i_rdata, bus.d_ack, bus.d_err, bus.d_rdata,
             bus.mem_address, bus.mem_data_in, bus.mem_read, bus.mem_write};
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    preset_req = 1'b1;
    for (int k = 0; k < int'(MEMB); k++) ref_mem[k] = 8'(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preset_req = 1'b0;
    #2 rst_n = 1'b1;
    tie_to_data = 1'b1;
  endtask

  // Raise the selected requests in one cycle; each port drops its request after its ack.
  // Cycle numbers count from the cycle the requests first appear (cycle 0).
  task automatic run_pair(input bit ri, input logic [63:0] ia,
                          input bit rd, input bit dwe, input logic [63:0] da, input logic [63:0] dwd,
                          output int ic, output logic [63:0] idat, output bit ie,
                          output int dc, output logic [63:0] ddat, output bit de);
    bit pi, pd;
    int cyc;
    ic = -1; dc = -1; idat = '0; ddat = '0; ie = 1'b0; de = 1'b0;
    pi = ri; pd = rd; cyc = 0;
    @(posedge clk); #1;
    bus.i_req = ri; bus.i_addr = ia;
    bus.d_req = rd; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    while (pi || pd) begin
      @(negedge clk);
      if (bus.i_ack) begin
        if (pi) begin ic = cyc; idat = bus.i_rdata; ie = bus.i_err; pi = 1'b0; end
        else spurious++;
      end else if (bus.i_err || bus.i_rdata != 0) spurious++;
      if (bus.d_ack) begin
        if (pd) begin dc = cyc; ddat = bus.d_rdata; de = bus.d_err; pd = 1'b0; end
        else spurious++;
      end else if (bus.d_err || bus.d_rdata != 0) spurious++;
      if (cyc >= 60) begin
        checks++; failures++;
        $display("FAIL pair_timeout cycles=%0d pending_i=%0d pending_d=%0d", cyc, pi, pd);
        pi = 1'b0; pd = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (!pi) bus.i_req = 1'b0;
      if (!pd) bus.d_req = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs_nonzero() !== 1'b0) begin failures++; $display("FAIL reset_during got=%0b exp=0", outs_nonzero()); end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (outs_nonzero() !== 1'b0) begin failures++; $display("FAIL reset_idle cyc=%0d got=%0b exp=0", c, outs_nonzero()); end
    end
  endtask

  task automatic test_fetch();
    int ic, dc, r0, w0, s0; logic [63:0] idat, ddat, xd; bit ie, de, xe;
    r0 = rd_cycles; w0 = wr_pulses; s0 = spurious;
    run_pair(1'b1, 64'h10, 1'b0, 1'b0, '0, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h10, '0, xd, xe);
    tie_to_data = 1'b1;
    checks++; if (ic !== 3) begin failures++; $display("FAIL fetch_latency got=%0d exp=3", ic); end
    checks++; if (idat !== 64'h1716151413121110) begin failures++; $display("FAIL fetch_data got=%h exp=1716151413121110", idat); end
    checks++; if (idat !== xd) begin failures++; $display("FAIL fetch_model got=%h exp=%h", idat, xd); end
    checks++; if (ie !== 1'b0) begin failures++; $display("FAIL fetch_err got=%0b exp=0", ie); end
    checks++; if (rd_cycles - r0 !== int'(RC)) begin failures++; $display("FAIL fetch_read_cycles got=%0d exp=%0d", rd_cycles - r0, RC); end
    checks++; if (wr_pulses - w0 !== 0 || spurious - s0 !== 0) begin failures++; $display("FAIL fetch_side got=%0d/%0d exp=0/0", wr_pulses - w0, spurious - s0); end
  endtask

  task automatic test_store_load();
    int ic, dc, w0; logic [63:0] idat, ddat, xd; bit ie, de, xe;
    w0 = wr_pulses;
    run_pair(1'b0, '0, 1'b1, 1'b1, 64'h20, 64'hDEADBEEF_CAFEF00D, ic, idat, ie, dc, ddat, de);
    model_apply(1'b1, 64'h20, 64'hDEADBEEF_CAFEF00D, xd, xe);
    tie_to_data = 1'b0;
    checks++; if (dc !== 9) begin failures++; $display("FAIL store_latency got=%0d exp=9", dc); end
    checks++; if (ddat !== 64'h0 || de !== 1'b0) begin failures++; $display("FAIL store_resp got=%h/%0b exp=0/0", ddat, de); end
    checks++; if (wr_pulses - w0 !== 1) begin failures++; $display("FAIL store_pulses got=%0d exp=1", wr_pulses - w0); end
    run_pair(1'b0, '0, 1'b1, 1'b0, 64'h20, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h20, '0, xd, xe);
    checks++; if (dc !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", dc); end
    checks++; if (ddat !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("FAIL load_data got=%h exp=deadbeefcafef00d", ddat); end
  endtask

  task automatic test_back_to_back();
    int ic, dc; logic [63:0] idat, ddat, xi, xd, wd; bit ie, de, ei, ed;
    do_reset();
    // Tie right after reset: data first, fetch C+2 cycles after it.
    run_pair(1'b1, 64'h08, 1'b1, 1'b0, 64'h30, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h30, '0, xd, ed); model_apply(1'b0, 64'h08, '0, xi, ei);
    checks++; if (dc !== 3 || ic !== 7) begin failures++; $display("FAIL tie1_order got=d%0d,i%0d exp=d3,i7", dc, ic); end
    checks++; if (ddat !== xd || idat !== xi) begin failures++; $display("FAIL tie1_data got=%h,%h exp=%h,%h", ddat, idat, xd, xi); end
    // Fetch was last, so data wins again; fetch of the same word sees the new store.
    wd = {32'($urandom), 32'($urandom)};
    run_pair(1'b1, 64'h40, 1'b1, 1'b1, 64'h40, wd, ic, idat, ie, dc, ddat, de);
    model_apply(1'b1, 64'h40, wd, xd, ed); model_apply(1'b0, 64'h40, '0, xi, ei);
    checks++; if (dc !== 9 || ic !== 13) begin failures++; $display("FAIL tie2_order got=d%0d,i%0d exp=d9,i13", dc, ic); end
    checks++; if (idat !== xi || idat !== wd) begin failures++; $display("FAIL tie2_fetch_data got=%h exp=%h", idat, wd); end
    // Data served alone, then a tie goes to fetch.
    run_pair(1'b0, '0, 1'b1, 1'b0, 64'h00, '0, ic, idat, ie, dc, ddat, de);
    checks++; if (dc !== 3) begin failures++; $display("FAIL solo_data got=%0d exp=3", dc); end
    run_pair(1'b1, 64'h48, 1'b1, 1'b0, 64'h10, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h48, '0, xi, ei); model_apply(1'b0, 64'h10, '0, xd, ed);
    tie_to_data = 1'b1;
    checks++; if (ic !== 3 || dc !== 7) begin failures++; $display("FAIL tie3_order got=i%0d,d%0d exp=i3,d7", ic, dc); end
    checks++; if (idat !== xi || ddat !== xd) begin failures++; $display("FAIL tie3_data got=%h,%h exp=%h,%h", idat, ddat, xi, xd); end
  endtask

  task automatic test_range_err();
    int ic, dc, r0, w0; logic [63:0] idat, ddat, xd; bit ie, de, xe;
    r0 = rd_cycles; w0 = wr_pulses;
    run_pair(1'b0, '0, 1'b1, 1'b0, 64'h79, '0, ic, idat, ie, dc, ddat, de);
    checks++; if (dc !== 1 || de !== 1'b1 || ddat !== 64'h0) begin failures++; $display("FAIL err_load got=%0d/%0b/%h exp=1/1/0", dc, de, ddat); end
    run_pair(1'b0, '0, 1'b1, 1'b1, 64'h79, 64'h1234_5678_9ABC_DEF0, ic, idat, ie, dc, ddat, de);
    checks++; if (dc !== 1 || de !== 1'b1 || ddat !== 64'h0) begin failures++; $display("FAIL err_store got=%0d/%0b/%h exp=1/1/0", dc, de, ddat); end
    run_pair(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, '0, '0, ic, idat, ie, dc, ddat, de);
    checks++; if (ic !== 1 || ie !== 1'b1 || idat !== 64'h0) begin failures++; $display("FAIL err_wrap got=%0d/%0b/%h exp=1/1/0", ic, ie, idat); end
    checks++; if (rd_cycles - r0 !== 0 || wr_pulses - w0 !== 0) begin failures++; $display("FAIL err_mem_touch got=%0d/%0d exp=0/0", rd_cycles - r0, wr_pulses - w0); end
    run_pair(1'b0, '0, 1'b1, 1'b0, 64'h78, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h78, '0, xd, xe);
    tie_to_data = 1'b0;
    checks++; if (dc !== 3 || de !== 1'b0 || ddat !== xd) begin failures++; $display("FAIL edge_load got=%0d/%0b/%h exp=3/0/%h", dc, de, ddat, xd); end
  endtask

  task automatic test_reset_mid_store();
    int acks, ic, dc; logic [63:0] idat, ddat, xi, xd; bit ie, de, ei, ed;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h60; bus.d_wdata = {32'($urandom), 32'($urandom)};
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin failures++; $display("FAIL abort_ctrl got=%b exp=00", {bus.mem_read, bus.mem_write}); end
    checks++; if (outs_nonzero() !== 1'b0) begin failures++; $display("FAIL abort_outs got=%0b exp=0", outs_nonzero()); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    acks = 0;
    repeat (12) begin @(negedge clk); if (bus.i_ack || bus.d_ack) acks++; end
    checks++; if (acks !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    // The word at 0x60 may be partially written; only untouched words are used below.
    run_pair(1'b1, 64'h00, 1'b1, 1'b0, 64'h08, '0, ic, idat, ie, dc, ddat, de);
    model_apply(1'b0, 64'h08, '0, xd, ed); model_apply(1'b0, 64'h00, '0, xi, ei);
    checks++; if (dc !== 3 || ic !== 7) begin failures++; $display("FAIL abort_tie got=d%0d,i%0d exp=d3,i7", dc, ic); end
    checks++; if (ddat !== xd || idat !== xi) begin failures++; $display("FAIL abort_data got=%h,%h exp=%h,%h", ddat, idat, xd, xi); end
  endtask

  task automatic test_random();
    int r0, w0, s0, exp_rd, exp_wr;
    do_reset();
    r0 = rd_cycles; w0 = wr_pulses; s0 = spurious; exp_rd = 0; exp_wr = 0;
    for (int it = 0; it < 40; it++) begin
      bit ri, rd, dwe, ie, de, ei, ed, i_first;
      logic [63:0] ia, da, dwd, idat, ddat, xi, xd;
      int ic, dc, xic, xdc;
      ri = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      ia = rand_addr(); da = rand_addr(); dwe = 1'($urandom_range(0, 1));
      dwd = {32'($urandom), 32'($urandom)};
      i_first = ri && (!rd || !tie_to_data);
      run_pair(ri, ia, rd, dwe, da, dwd, ic, idat, ie, dc, ddat, de);
      xi = '0; xd = '0; ei = 1'b0; ed = 1'b0; xic = -1; xdc = -1;
      if (i_first) begin
        model_apply(1'b0, ia, '0, xi, ei); xic = exp_lat(1'b0, !ei); tie_to_data = 1'b1;
        if (rd) begin model_apply(dwe, da, dwd, xd, ed); xdc = xic + 1 + exp_lat(dwe, !ed); tie_to_data = 1'b0; end
      end else begin
        model_apply(dwe, da, dwd, xd, ed); xdc = exp_lat(dwe, !ed); tie_to_data = 1'b0;
        if (ri) begin model_apply(1'b0, ia, '0, xi, ei); xic = xdc + 1 + exp_lat(1'b0, !ei); tie_to_data = 1'b1; end
      end
      if (ri && !ei) exp_rd += int'(RC);
      if (rd && !ed) begin if (dwe) exp_wr++; else exp_rd += int'(RC); end
      if (ri) begin
        checks++;
        if (ic !== xic || idat !== xi || ie !== ei) begin
          failures++; $display("FAIL rand_fetch it=%0d addr=%h got=%0d/%h/%0b exp=%0d/%h/%0b", it, ia, ic, idat, ie, xic, xi, ei);
        end
      end
      if (rd) begin
        checks++;
        if (dc !== xdc || ddat !== xd || de !== ed) begin
          failures++; $display("FAIL rand_data it=%0d we=%0b addr=%h got=%0d/%h/%0b exp=%0d/%h/%0b", it, dwe, da, dc, ddat, de, xdc, xd, ed);
        end
      end
    end
    checks++; if (rd_cycles - r0 !== exp_rd) begin failures++; $display("FAIL rand_read_cycles got=%0d exp=%0d", rd_cycles - r0, exp_rd); end
    checks++; if (wr_pulses - w0 !== exp_wr) begin failures++; $display("FAIL rand_write_pulses got=%0d exp=%0d", wr_pulses - w0, exp_wr); end
    checks++; if (spurious - s0 !== 0) begin failures++; $display("FAIL rand_idle_port got=%0d exp=0", spurious - s0); end
  endtask

  task automatic test_mem_protocol();
    checks++; if (viol !== 0) begin failures++; $display("FAIL mem_protocol violations got=%0d exp=0", viol); end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL idle_port_outputs got=%0d exp=0", spurious); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_range_err();
    test_reset_mid_store();
    test_random();
    test_mem_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t limit=500000", $time);
    $fatal(1, "timeout");
  end

endmodule
